// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction encoder/loader: field positions,
// instruction ID and opcode constants, encoding forms and the loader FSM states.
package isa_pkg;

  // Bit positions of the machine-word fields
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;
  localparam int FN_LSB = 0;

  // Instruction IDs (decoder numbering, 1-29)
  localparam logic [31:0] ID_MIN       = 32'd1;
  localparam logic [31:0] ID_ALU_LAST  = 32'd4;
  localparam logic [31:0] ID_I5        = 32'd5;
  localparam logic [31:0] ID_I6        = 32'd6;
  localparam logic [31:0] ID_R7        = 32'd7;
  localparam logic [31:0] ID_R8        = 32'd8;
  localparam logic [31:0] ID_I9        = 32'd9;
  localparam logic [31:0] ID_I10       = 32'd10;
  localparam logic [31:0] ID_SHIFT_A   = 32'd11;
  localparam logic [31:0] ID_SHIFT_B   = 32'd12;
  localparam logic [31:0] ID_I_FIRST   = 32'd13;
  localparam logic [31:0] ID_I_LAST    = 32'd20;
  localparam logic [31:0] ID_J_FIRST   = 32'd21;
  localparam logic [31:0] ID_J_LAST    = 32'd23;
  localparam logic [31:0] ID_R24       = 32'd24;
  localparam logic [31:0] ID_I25       = 32'd25;
  localparam logic [31:0] ID_SYS_FIRST = 32'd26;
  localparam logic [31:0] ID_MAX       = 32'd29;

  // Opcodes that are not a plain offset of the ID
  localparam logic [5:0] OP_ALU   = 6'd0;
  localparam logic [5:0] OP_R7    = 6'd3;
  localparam logic [5:0] OP_R8    = 6'd4;
  localparam logic [5:0] OP_SHIFT = 6'd7;
  localparam logic [5:0] OP_R24   = 6'd19;
  localparam logic [5:0] OP_I25   = 6'd20;
  localparam logic [5:0] OP_SYS   = 6'd21;
  localparam logic [5:0] FN_NONE  = 6'd0;

  typedef enum logic [2:0] {FORM_BAD, FORM_R, FORM_I, FORM_SH, FORM_J, FORM_SYS} form_t;

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_WRITE, ST_DONE, ST_HALT} state_t;

  // Register/shift form: op | rs | rt | rd | sh | fn
  function automatic logic [31:0] pack_r(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[RD_LSB +: 5] = rd;
    w[SH_LSB +: 5] = sh;
    w[FN_LSB +: 6] = fn;
    return w;
  endfunction

  // Immediate form: op | rs | rt | imm16
  function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[RS_LSB +: 5] = rs;
    w[RT_LSB +: 5] = rt;
    w[15:0]        = imm;
    return w;
  endfunction

  // Jump form: op | target26
  function automatic logic [31:0] pack_j(input logic [5:0] op, input logic [25:0] tgt);
    logic [31:0] w;
    w = '0;
    w[OP_LSB +: 6] = op;
    w[25:0]        = tgt;
    return w;
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: decoded tuple (id, rs, rt, rd) to a 32-bit machine word,
// with flags for unknown IDs and operands that do not fit their fields.
module instr_encode
  import isa_pkg::*;
(
  input  logic [31:0] id,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] rd,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  logic       rs_big, rt_big, rd_big, imm_big, tgt_big;
  logic [5:0] id6;
  form_t      form;
  logic [5:0] op;
  logic [5:0] fn;

  assign rs_big  = (rs > 32'd31);
  assign rt_big  = (rt > 32'd31);
  assign rd_big  = (rd > 32'd31);
  // Immediate must survive a round trip through its sign-extended low half
  assign imm_big = (rt != {{16{rt[15]}}, rt[15:0]});
  assign tgt_big = (rs[31:26] != 6'd0);
  // Low ID bits only feed offsets; the full ID decides the class below
  assign id6     = id[5:0];

  // Classify the ID into an encoding form and pick opcode / function code
  always_comb begin
    form = FORM_BAD;
    op   = OP_ALU;
    fn   = FN_NONE;
    if (id >= ID_MIN && id <= ID_ALU_LAST) begin
      form = FORM_R;  op = OP_ALU;  fn = id6 - 6'd1;
    end else if (id == ID_R7) begin
      form = FORM_R;  op = OP_R7;
    end else if (id == ID_R8) begin
      form = FORM_R;  op = OP_R8;
    end else if (id == ID_R24) begin
      form = FORM_R;  op = OP_R24;
    end else if (id == ID_I5 || id == ID_I6 || id == ID_I9 || id == ID_I10) begin
      form = FORM_I;  op = id6 - 6'd4;
    end else if (id >= ID_I_FIRST && id <= ID_I_LAST) begin
      form = FORM_I;  op = id6 - 6'd5;
    end else if (id == ID_I25) begin
      form = FORM_I;  op = OP_I25;
    end else if (id == ID_SHIFT_A || id == ID_SHIFT_B) begin
      form = FORM_SH; op = OP_SHIFT; fn = id6 - 6'd11;
    end else if (id >= ID_J_FIRST && id <= ID_J_LAST) begin
      form = FORM_J;  op = id6 - 6'd5;
    end else if (id >= ID_SYS_FIRST && id <= ID_MAX) begin
      form = FORM_SYS; op = OP_SYS; fn = id6 - 6'd26;
    end
  end

  // Assemble the word for the selected form and check that every field fits
  always_comb begin
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (form)
      FORM_R: begin
        word      = pack_r(op, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn);
        range_err = rs_big | rt_big | rd_big;
      end
      FORM_I: begin
        // rd lands in the rt slot; rt carries the immediate
        word      = pack_i(op, rs[4:0], rd[4:0], rt[15:0]);
        range_err = rs_big | rd_big | imm_big;
      end
      FORM_SH: begin
        word      = pack_r(op, rs[4:0], rd[4:0], 5'd0, rt[4:0], fn);
        range_err = rs_big | rd_big | rt_big;
      end
      FORM_J: begin
        word      = pack_j(op, rs[25:0]);
        range_err = tgt_big;
      end
      FORM_SYS: begin
        word = pack_r(op, 5'd0, 5'd0, 5'd0, 5'd0, fn);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: encodes a stream of decoded tuples and writes the words to
// instruction memory from a base address, with sticky error reporting.
module instr_encode_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [31:0]       in_id,
  input  logic [31:0]       in_rs,
  input  logic [31:0]       in_rt,
  input  logic [31:0]       in_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_range,
  output logic              err_overflow
);

  // One extra address bit so the pointer can step past the last word
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

  state_t          state_reg, state_next;
  logic [ADDR_W:0] addr_reg;
  logic [ADDR_W:0] count_reg;
  logic [31:0]     wdata_reg;
  logic            last_reg;
  logic            err_illegal_reg, err_range_reg, err_overflow_reg;

  logic [31:0] enc_word;
  logic        enc_illegal, enc_range;
  logic        word_bad, addr_ok, accept, start_ok;

  instr_encode u_encode (
    .id        (in_id),
    .rs        (in_rs),
    .rt        (in_rt),
    .rd        (in_rd),
    .word      (enc_word),
    .illegal   (enc_illegal),
    .range_err (enc_range)
  );

  assign word_bad = enc_illegal | enc_range;
  assign addr_ok  = (addr_reg < DEPTH_L);
  assign accept   = in_valid & in_ready;
  assign start_ok = start & ((state_reg == ST_IDLE) | (state_reg == ST_HALT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state and handshake/strobe outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (word_bad) begin
            if (in_last) state_next = ST_DONE;
          end else if (addr_ok) begin
            state_next = ST_WRITE;
          end else begin
            state_next = ST_HALT;
          end
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (mem_ack) state_next = last_reg ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_HALT: begin
        if (start) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Address, count, write data and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg         <= '0;
      count_reg        <= '0;
      wdata_reg        <= '0;
      last_reg         <= 1'b0;
      err_illegal_reg  <= 1'b0;
      err_range_reg    <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      if (start_ok) begin
        addr_reg         <= {1'b0, base_addr};
        count_reg        <= '0;
        err_illegal_reg  <= 1'b0;
        err_range_reg    <= 1'b0;
        err_overflow_reg <= 1'b0;
      end
      if (accept) begin
        if (enc_illegal) err_illegal_reg <= 1'b1;
        if (enc_range)   err_range_reg   <= 1'b1;
        if (!word_bad) begin
          wdata_reg <= enc_word;
          last_reg  <= in_last;
          if (!addr_ok) err_overflow_reg <= 1'b1;
        end
      end
      if (state_reg == ST_WRITE && mem_ack) begin
        addr_reg  <= addr_reg + 1'b1;
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign mem_addr     = addr_reg[ADDR_W-1:0];
  assign mem_wdata    = wdata_reg;
  assign busy         = (state_reg != ST_IDLE);
  assign count        = count_reg;
  assign err_illegal  = err_illegal_reg;
  assign err_range    = err_range_reg;
  assign err_overflow = err_overflow_reg;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: reset state, a vector table of encodings,
// hand-written multi-cycle sequences and randomized programs against a model.
module tb_instr_encode_loader;

  localparam int ADDR_W    = 10;
  localparam int MEM_DEPTH = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [31:0]       in_id = '0, in_rs = '0, in_rt = '0, in_rd = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack = 1'b0;
  logic              busy, done;
  logic [ADDR_W:0]   count;
  logic              err_illegal, err_range, err_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encode_loader #(.ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_id(in_id), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .count(count),
    .err_illegal(err_illegal), .err_range(err_range), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id, rs, rt, rd;
    logic [31:0] word;
    bit          ill;
    bit          rng;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Reference encoder built straight from the ID table with plain arithmetic
  function automatic void ref_encode(input logic [31:0] id, input logic [31:0] rs,
                                     input logic [31:0] rt, input logic [31:0] rd,
                                     output logic [31:0] w, output bit ill, output bit rng);
    longint unsigned a, b, c, acc, op, fn;
    int srt;
    a = rs; b = rt; c = rd; srt = $signed(rt);
    acc = 0; ill = 0; rng = 0;
    if (id inside {[1:4], 7, 8, 24}) begin
      op  = (id <= 4) ? 0 : (id == 7) ? 3 : (id == 8) ? 4 : 19;
      fn  = (id <= 4) ? longint'(id) - 1 : 0;
      rng = (a > 31) || (b > 31) || (c > 31);
      acc = op * 2**26 + (a % 32) * 2**21 + (b % 32) * 2**16 + (c % 32) * 2**11 + fn;
    end else if (id inside {5, 6, 9, 10, [13:20], 25}) begin
      op  = (id == 25) ? 20 : (id <= 10) ? longint'(id) - 4 : longint'(id) - 5;
      rng = (a > 31) || (c > 31) || (srt < -32768) || (srt > 32767);
      acc = op * 2**26 + (a % 32) * 2**21 + (c % 32) * 2**16 + (b % 65536);
    end else if (id inside {11, 12}) begin
      rng = (a > 31) || (c > 31) || (b > 31);
      acc = 7 * 2**26 + (a % 32) * 2**21 + (c % 32) * 2**16 + (b % 32) * 2**6 + (longint'(id) - 11);
    end else if (id inside {[21:23]}) begin
      rng = (a >= 2**26);
      acc = (longint'(id) - 5) * 2**26 + (a % 2**26);
    end else if (id inside {[26:29]}) begin
      acc = 21 * 2**26 + (longint'(id) - 26);
    end else begin
      ill = 1;
    end
    w = acc[31:0];
  endfunction

  task automatic do_start(input logic [ADDR_W-1:0] base);
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one tuple and wait (bounded) for the handshake edge
  task automatic offer(input logic [31:0] id, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] rd, input logic last, output bit ok);
    in_valid = 1'b1; in_id = id; in_rs = rs; in_rt = rt; in_rd = rd; in_last = last;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin @(posedge clk); #1; end
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL handshake timeout id=%0d: got in_ready=0, want 1 within 20 cycles", id);
    end
  endtask

  // Check a pending write, hold ack low for lat cycles, then acknowledge it
  task automatic expect_write(input string tag, input logic [ADDR_W-1:0] a,
                              input logic [31:0] w, input int lat);
    check({tag, " mem_we"}, 32'(mem_we), 32'd1);
    check({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
    check({tag, " mem_wdata"}, mem_wdata, w);
    for (int k = 0; k < lat; k++) begin
      @(posedge clk); #1;
      check({tag, " hold mem_we"}, 32'(mem_we), 32'd1);
      check({tag, " hold mem_addr"}, 32'(mem_addr), 32'(a));
      check({tag, " hold mem_wdata"}, mem_wdata, w);
      check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
    end
    $display("write %s addr=%0d data=0x%08h ack_delay=%0d", tag, a, w, lat);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vecs[0]  = '{32'd1,  32'd1,    32'd2,        32'd3, 32'h00221800, 0, 0};
    vecs[1]  = '{32'd5,  32'd1,    32'hFFFFFFFF, 32'd4, 32'h0424FFFF, 0, 0};
    vecs[2]  = '{32'd12, 32'd1,    32'd5,        32'd2, 32'h1C220141, 0, 0};
    vecs[3]  = '{32'd23, 32'd1000, 32'd0,        32'd0, 32'h480003E8, 0, 0};
    vecs[4]  = '{32'd28, 32'd0,    32'd0,        32'd0, 32'h54000002, 0, 0};
    vecs[5]  = '{32'd7,  32'd31,   32'd0,        32'd5, 32'h0FE02800, 0, 0};
    vecs[6]  = '{32'd0,  32'd0,    32'd0,        32'd0, 32'h0,        1, 0};
    vecs[7]  = '{32'd30, 32'd0,    32'd0,        32'd0, 32'h0,        1, 0};
    vecs[8]  = '{32'd5,  32'd1,    32'd40000,    32'd4, 32'h0,        0, 1};
    vecs[9]  = '{32'd2,  32'd32,   32'd0,        32'd0, 32'h0,        0, 1};
    vecs[10] = '{32'd22, 32'h04000000, 32'd0,    32'd0, 32'h0,        0, 1};
    vecs[11] = '{32'd11, 32'd1,    32'd32,       32'd2, 32'h0,        0, 1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", 32'(mem_addr), 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst count", 32'(count), 32'd0);
    check("rst err_illegal", 32'(err_illegal), 32'd0);
    check("rst err_range", 32'(err_range), 32'd0);
    check("rst err_overflow", 32'(err_overflow), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Vector table: each entry is a one-word program
    for (int i = 0; i < 12; i++) begin
      logic [ADDR_W-1:0] b;
      string tag;
      b = ADDR_W'(i * 37);
      tag = $sformatf("vec%0d", i);
      do_start(b);
      offer(vecs[i].id, vecs[i].rs, vecs[i].rt, vecs[i].rd, 1'b1, ok);
      if (!vecs[i].ill && !vecs[i].rng) begin
        expect_write(tag, b, vecs[i].word, i % 3);
        check({tag, " count"}, 32'(count), 32'd1);
      end else begin
        $display("drop %s id=%0d", tag, vecs[i].id);
        check({tag, " no mem_we"}, 32'(mem_we), 32'd0);
        check({tag, " count"}, 32'(count), 32'd0);
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " err_illegal"}, 32'(err_illegal), 32'(vecs[i].ill));
      check({tag, " err_range"}, 32'(err_range), 32'(vecs[i].rng));
      @(posedge clk); #1;
      check({tag, " done pulse"}, 32'(done), 32'd0);
      check({tag, " idle"}, 32'(busy), 32'd0);
    end

    // Two-word program, second write acked after a 3-cycle stall
    do_start(10'd0);
    offer(32'd5, 32'd1, 32'hFFFFFFFF, 32'd4, 1'b0, ok);
    expect_write("seq2 w0", 10'd0, 32'h0424FFFF, 0);
    check("seq2 no done", 32'(done), 32'd0);
    check("seq2 busy", 32'(busy), 32'd1);
    offer(32'd12, 32'd1, 32'd5, 32'd2, 1'b1, ok);
    expect_write("seq2 w1", 10'd1, 32'h1C220141, 3);
    check("seq2 done", 32'(done), 32'd1);
    check("seq2 count", 32'(count), 32'd2);
    @(posedge clk); #1;
    check("seq2 done once", 32'(done), 32'd0);

    // Dropped words, ignored start and stray ack while running
    do_start(10'd5);
    offer(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, ok);
    check("drop id0 mem_we", 32'(mem_we), 32'd0);
    offer(32'd30, 32'd0, 32'd0, 32'd0, 1'b0, ok);
    offer(32'd5, 32'd1, 32'd40000, 32'd4, 1'b0, ok);
    $display("drop sequence ids 0,30,5(rt=40000)");
    check("drop err_illegal", 32'(err_illegal), 32'd1);
    check("drop err_range", 32'(err_range), 32'd1);
    check("drop count", 32'(count), 32'd0);
    check("drop mem_we", 32'(mem_we), 32'd0);
    start = 1'b1; base_addr = 10'd99; mem_ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b0;
    check("run start ignored err", 32'(err_illegal), 32'd1);
    check("stray ack count", 32'(count), 32'd0);
    check("run in_ready", 32'(in_ready), 32'd1);
    offer(32'd1, 32'd1, 32'd2, 32'd3, 1'b1, ok);
    expect_write("drop next", 10'd5, 32'h00221800, 0);
    check("drop next done", 32'(done), 32'd1);
    check("drop next count", 32'(count), 32'd1);
    @(posedge clk); #1;

    // Overflow at the top of memory, then re-arm from HALT
    do_start(10'd1023);
    offer(32'd28, 32'd0, 32'd0, 32'd0, 1'b0, ok);
    expect_write("ovf w0", 10'd1023, 32'h54000002, 1);
    offer(32'd26, 32'd0, 32'd0, 32'd0, 1'b0, ok);
    $display("overflow word id=26 at addr 1024");
    check("ovf flag", 32'(err_overflow), 32'd1);
    check("ovf mem_we", 32'(mem_we), 32'd0);
    check("ovf in_ready", 32'(in_ready), 32'd0);
    check("ovf busy", 32'(busy), 32'd1);
    check("ovf count", 32'(count), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("halt in_ready", 32'(in_ready), 32'd0);
    do_start(10'd7);
    check("rearm err_overflow", 32'(err_overflow), 32'd0);
    check("rearm count", 32'(count), 32'd0);
    check("rearm in_ready", 32'(in_ready), 32'd1);
    offer(32'd1, 32'd1, 32'd2, 32'd3, 1'b1, ok);
    expect_write("rearm w0", 10'd7, 32'h00221800, 0);
    check("rearm done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Reset during a pending write drops mem_we at once
    do_start(10'd3);
    offer(32'd1, 32'd1, 32'd2, 32'd3, 1'b0, ok);
    check("mid-write mem_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    $display("reset asserted during write");
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomized programs against the reference model
    for (int p = 0; p < 6; p++) begin
      logic [ADDR_W-1:0] b;
      logic [31:0] id, rs, rt, rd, w;
      bit ill, rng, m_ill, m_rng, m_ovf, halted, last;
      int m_addr, m_count, n, r;
      b = ($urandom_range(0, 2) == 0) ? ADDR_W'(MEM_DEPTH - int'($urandom_range(1, 4)))
                                      : ADDR_W'($urandom_range(0, 1000));
      n = $urandom_range(4, 16);
      do_start(b);
      m_addr = int'(b); m_count = 0; m_ill = 0; m_rng = 0; m_ovf = 0; halted = 0;
      for (int k = 0; k < n && !halted; k++) begin
        id = $urandom_range(0, 31);
        r  = $urandom_range(0, 9);
        rs = (r == 0) ? $urandom : (r == 1) ? ($urandom & 32'h03FF_FFFF) : 32'($urandom_range(0, 31));
        r  = $urandom_range(0, 9);
        rt = (r == 0) ? $urandom : (r < 4) ? {{16{1'b0}}, 16'($urandom)} : 32'($urandom_range(0, 31));
        if (r == 2) rt = {{16{rt[15]}}, rt[15:0]};
        r  = $urandom_range(0, 9);
        rd = (r == 0) ? $urandom_range(32, 100) : 32'($urandom_range(0, 31));
        last = (k == n - 1);
        ref_encode(id, rs, rt, rd, w, ill, rng);
        offer(id, rs, rt, rd, last, ok);
        if (!ok) begin
          halted = 1;
        end else if (ill || rng) begin
          m_ill |= ill; m_rng |= rng;
          $display("drop rnd p%0d k%0d id=%0d ill=%0d rng=%0d", p, k, id, ill, rng);
          check("rnd drop mem_we", 32'(mem_we), 32'd0);
          if (last) check("rnd drop done", 32'(done), 32'd1);
        end else if (m_addr < MEM_DEPTH) begin
          expect_write($sformatf("rnd p%0d k%0d id=%0d", p, k, id), ADDR_W'(m_addr), w,
                       $urandom_range(0, 2));
          m_addr++; m_count++;
          check("rnd done", 32'(done), 32'(last));
        end else begin
          m_ovf = 1; halted = 1;
          $display("overflow rnd p%0d k%0d id=%0d", p, k, id);
          check("rnd ovf in_ready", 32'(in_ready), 32'd0);
          check("rnd ovf mem_we", 32'(mem_we), 32'd0);
        end
      end
      check("rnd count", 32'(count), 32'(m_count));
      check("rnd err_illegal", 32'(err_illegal), 32'(m_ill));
      check("rnd err_range", 32'(err_range), 32'(m_rng));
      check("rnd err_overflow", 32'(err_overflow), 32'(m_ovf));
      @(posedge clk); #1;
      check("rnd busy after end", 32'(busy), 32'(halted));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
